// File: rtl/inst_fetch_bridge.sv
// IF-stage fetch bridge: turns each PC fetch into a single read on an SRAM-like
// instruction bus and presents the returned word to the IF/ID boundary.
module inst_fetch_bridge #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              pc_ce,
  input  logic [ADDR_W-1:0] pc_addr,
  input  logic              stall_if,
  input  logic              flush,
  output logic              inst_req,
  output logic              inst_wr,
  output logic [1:0]        inst_size,
  output logic [ADDR_W-1:0] inst_addr,
  input  logic              inst_addr_ok,
  input  logic [DATA_W-1:0] inst_rdata,
  input  logic              inst_data_ok,
  output logic [DATA_W-1:0] if_inst,
  output logic [ADDR_W-1:0] if_pc,
  output logic              if_valid,
  output logic              if_adel,
  output logic              stallreq_if
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t            state, state_nxt;
  logic              discard, discard_nxt;
  logic              req_nxt;
  logic [ADDR_W-1:0] addr_nxt;
  logic [DATA_W-1:0] inst_nxt;
  logic [ADDR_W-1:0] pc_nxt;
  logic              valid_nxt;
  logic              adel_nxt;

  assign inst_wr   = 1'b0;
  assign inst_size = 2'b10;

  // The PC must be held from the moment a fetch is accepted until the word lands.
  assign stallreq_if = rstn && ((state == REQ) || (state == WAIT) ||
                                (state == IDLE && pc_ce && !flush));

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state     <= IDLE;
      discard   <= 1'b0;
      inst_req  <= 1'b0;
      inst_addr <= '0;
      if_inst   <= '0;
      if_pc     <= '0;
      if_valid  <= 1'b0;
      if_adel   <= 1'b0;
    end else begin
      state     <= state_nxt;
      discard   <= discard_nxt;
      inst_req  <= req_nxt;
      inst_addr <= addr_nxt;
      if_inst   <= inst_nxt;
      if_pc     <= pc_nxt;
      if_valid  <= valid_nxt;
      if_adel   <= adel_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    discard_nxt = discard;
    req_nxt     = inst_req;
    addr_nxt    = inst_addr;
    inst_nxt    = if_inst;
    pc_nxt      = if_pc;
    valid_nxt   = if_valid;
    adel_nxt    = if_adel;
    case (state)
      IDLE: begin
        if (pc_ce && !flush) begin
          if (pc_addr[1:0] != 2'b00) begin
            // Misaligned fetch is reported directly; the bus is never touched.
            state_nxt = DONE;
            adel_nxt  = 1'b1;
            inst_nxt  = '0;
            pc_nxt    = pc_addr;
            valid_nxt = 1'b1;
          end else begin
            state_nxt = REQ;
            req_nxt   = 1'b1;
            addr_nxt  = pc_addr;
          end
        end
      end
      REQ: begin
        // A request cannot be withdrawn once raised, so a flush only marks it.
        if (flush) discard_nxt = 1'b1;
        if (inst_addr_ok) begin
          req_nxt   = 1'b0;
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (inst_data_ok) begin
          if (discard || flush) begin
            state_nxt   = IDLE;
            discard_nxt = 1'b0;
          end else begin
            state_nxt = DONE;
            inst_nxt  = inst_rdata;
            pc_nxt    = inst_addr;
            adel_nxt  = 1'b0;
            valid_nxt = 1'b1;
          end
        end else if (flush) begin
          discard_nxt = 1'b1;
        end
      end
      DONE: begin
        if (!stall_if || flush) begin
          state_nxt = IDLE;
          valid_nxt = 1'b0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule
